ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes PS/2 set-2 scan-code bytes from the keyboard receiver FIFO and turns them into key events. It pops one byte at a time through the receiver's `ready`/`nextdata_n` handshake and folds `E0`/`F0` prefixes into a single event. Each event carries make/break, extended flag, typematic-repeat flag, shift-aware ASCII and a running keypress count. It sits directly downstream of the PS/2 receiver and feeds display/console logic.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, same domain as the receiver.
- `rst`  in  1  reset; asynchronous, active-high.
- `ps2_data`  in  8  scan-code byte at the receiver FIFO head; valid while `ps2_ready`=1.
- `ps2_ready`  in  1  receiver FIFO non-empty.
- `nextdata_n`  out  1  active-low pop strobe to the receiver; registered.
- `key_valid`  out  1  one-cycle event strobe.
- `key_code`  out  8  final (non-prefix) scan code of the event.
- `key_ext`  out  1  event was `E0`-prefixed.
- `key_release`  out  1  event was `F0`-prefixed (break).
- `key_repeat`  out  1  make event is a typematic repeat.
- `ascii`  out  8  ASCII of the key, 0 if unmapped.
- `key_count`  out  8  count of non-repeat make events.
- `shift_held`  out  1  left or right shift currently down.

## Operation
- FSM states: IDLE, POP, WAIT.
  - IDLE: if `ps2_ready`=1, latch `ps2_data` into `byte_r`, drive `nextdata_n`<=0, go to POP.
  - POP: `nextdata_n`<=1, decode `byte_r`, go to WAIT.
  - WAIT: go to IDLE. This gap lets the receiver's `ready` settle after the pop.
- `nextdata_n` is low for exactly one cycle per byte and only when `ps2_ready` was 1 in the preceding IDLE cycle.
- Decode in POP:
  - `E0`: set `ext_p`; no event.
  - `F0`: set `brk_p`; no event.
  - Any other byte: emit an event with `key_code`=byte, `key_ext`=`ext_p`, `key_release`=`brk_p`, then clear both prefix flags.
  - `E0 F0 xx`: event with ext=1, release=1.
  - `F0 E0`: also accepted; the flags are order-independent.
- Shift tracking:
  - Non-extended `12` (left) and `59` (right) set their held bit on make and clear it on break.
  - Extended `12`/`59` do not affect shift.
  - `shift_held` = left | right.
- Repeat:
  - `last_r` holds {ext,code} of the most recent make.
  - A make equal to `last_r` gives `key_repeat`=1.
  - A break equal to `last_r` clears `last_r` to invalid.
  - A break never sets `key_repeat`.
- `key_count` increments on every make with `key_repeat`=0, shift makes included. It is 8-bit and wraps 255->0.
- ASCII mapping (non-extended only; extended events give 0):
  - Letters, shift=0 gives lowercase, shift=1 gives uppercase: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits, shift-independent: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 gives 0x20; 5A gives 0x0D.
  - Everything else gives 0.
  - ASCII uses the shift state before the current event is applied; it is also computed for break events.

## Timing
- Reset (async): state IDLE, `nextdata_n`=1, all other outputs 0, prefix flags, shift bits and `last_r` cleared.
- `ps2_ready` sampled in IDLE at cycle T:
  - `nextdata_n`=0 during T+1.
  - Event outputs update at the end of T+1; `key_valid`=1 during T+2 only.
  - Next sample possible at T+3, giving a peak rate of 1 byte / 3 cycles.
- Event fields hold their value until the next event; only `key_valid` pulses.
- `ps2_ready` low in IDLE: no pop, no state change.
- Reset asserted mid-sequence, e.g. after `F0`: the prefix is lost, and the next byte decodes as a plain make.
- `ps2_data` is not sampled outside IDLE.

## Test plan
- Reset: assert `rst` asynchronously mid-POP -> `nextdata_n`=1 immediately, all outputs 0; the next byte is decoded fresh.
- Make/break: FIFO bytes 1C, F0, 1C -> two events:
  - (1C, ext 0, rel 0, ascii 0x61, count 1)
  - (1C, rel 1, ascii 0x61, count 1)
  - exactly three one-cycle `nextdata_n` pulses, each spaced ≥3 cycles.
- Shift: 12, 1C, F0 1C, F0 12, 1C -> events for 12 and F0 12 carry ascii 0; the first 1C gives ascii 0x41, `shift_held`=1; the final 1C gives 0x61, `shift_held`=0.
- Extended/repeat: E0 75, E0 75, E0 F0 75 -> ext=1 and ascii 0 on all; `key_repeat` 0,1,0; `key_count` +1 only.
- Handshake/starvation: `ps2_ready` toggled with gaps of 0–5 cycles -> no pop while `ps2_ready`=0, no double pop, `key_valid` exactly 2 cycles after each accepting IDLE cycle.
- Wrap: 256 distinct non-repeat makes (alternating 16/1E) -> `key_count` returns to 0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0
// prefixes and emits key events with shift-aware ASCII and repeat detection.
module ps2_scancode_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ps2_data,
   input  logic       ps2_ready,
   output logic       nextdata_n,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       key_repeat,
   output logic [7:0] ascii,
   output logic [7:0] key_count,
   output logic       shift_held
);

   typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

   state_t     state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       ext_p_q, ext_p_d;
   logic       brk_p_q, brk_p_d;
   logic       shl_q, shl_d;
   logic       shr_q, shr_d;
   logic       last_vld_q, last_vld_d;
   logic [8:0] last_key_q, last_key_d;
   logic       nextdata_n_q, nextdata_n_d;
   logic       key_valid_q, key_valid_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_ext_q, key_ext_d;
   logic       key_release_q, key_release_d;
   logic       key_repeat_q, key_repeat_d;
   logic [7:0] ascii_q, ascii_d;
   logic [7:0] key_count_q, key_count_d;
   logic       last_hit;

   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
      logic [7:0] letter;
      logic [7:0] other;
      letter = 8'h00;
      other  = 8'h00;
      case (code)
         8'h1C: letter = "a";
         8'h32: letter = "b";
         8'h21: letter = "c";
         8'h23: letter = "d";
         8'h24: letter = "e";
         8'h2B: letter = "f";
         8'h34: letter = "g";
         8'h33: letter = "h";
         8'h43: letter = "i";
         8'h3B: letter = "j";
         8'h42: letter = "k";
         8'h4B: letter = "l";
         8'h3A: letter = "m";
         8'h31: letter = "n";
         8'h44: letter = "o";
         8'h4D: letter = "p";
         8'h15: letter = "q";
         8'h2D: letter = "r";
         8'h1B: letter = "s";
         8'h2C: letter = "t";
         8'h3C: letter = "u";
         8'h2A: letter = "v";
         8'h1D: letter = "w";
         8'h22: letter = "x";
         8'h35: letter = "y";
         8'h1A: letter = "z";
         default: letter = 8'h00;
      endcase
      case (code)
         8'h45: other = "0";
         8'h16: other = "1";
         8'h1E: other = "2";
         8'h26: other = "3";
         8'h25: other = "4";
         8'h2E: other = "5";
         8'h36: other = "6";
         8'h3D: other = "7";
         8'h3E: other = "8";
         8'h46: other = "9";
         8'h29: other = 8'h20;
         8'h5A: other = 8'h0D;
         default: other = 8'h00;
      endcase
      if (letter != 8'h00) begin
         return shift ? (letter - 8'h20) : letter;
      end
      return other;
   endfunction

   // Repeat/release matching compares the full {ext,code} identity of the key.
   assign last_hit = last_vld_q && (last_key_q == {ext_p_q, byte_q});

   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      ext_p_d       = ext_p_q;
      brk_p_d       = brk_p_q;
      shl_d         = shl_q;
      shr_d         = shr_q;
      last_vld_d    = last_vld_q;
      last_key_d    = last_key_q;
      nextdata_n_d  = nextdata_n_q;
      key_valid_d   = 1'b0;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_release_d = key_release_q;
      key_repeat_d  = key_repeat_q;
      ascii_d       = ascii_q;
      key_count_d   = key_count_q;
      case (state_q)
         IDLE: begin
            if (ps2_ready) begin
               byte_d       = ps2_data;
               nextdata_n_d = 1'b0;
               state_d      = POP;
            end
         end
         POP: begin
            nextdata_n_d = 1'b1;
            state_d      = WAIT;
            if (byte_q == 8'hE0) begin
               ext_p_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
               brk_p_d = 1'b1;
            end else begin
               key_valid_d   = 1'b1;
               key_code_d    = byte_q;
               key_ext_d     = ext_p_q;
               key_release_d = brk_p_q;
               // ASCII sees the shift state from before this event.
               ascii_d       = ext_p_q ? 8'h00 : scan_to_ascii(byte_q, shl_q | shr_q);
               if (!brk_p_q) begin
                  key_repeat_d = last_hit;
                  if (!last_hit) begin
                     key_count_d = key_count_q + 8'd1;
                  end
                  last_vld_d = 1'b1;
                  last_key_d = {ext_p_q, byte_q};
               end else begin
                  key_repeat_d = 1'b0;
                  if (last_hit) begin
                     last_vld_d = 1'b0;
                  end
               end
               if (!ext_p_q && byte_q == 8'h12) begin
                  shl_d = !brk_p_q;
               end
               if (!ext_p_q && byte_q == 8'h59) begin
                  shr_d = !brk_p_q;
               end
               ext_p_d = 1'b0;
               brk_p_d = 1'b0;
            end
         end
         WAIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         byte_q        <= 8'h00;
         ext_p_q       <= 1'b0;
         brk_p_q       <= 1'b0;
         shl_q         <= 1'b0;
         shr_q         <= 1'b0;
         last_vld_q    <= 1'b0;
         last_key_q    <= 9'h000;
         nextdata_n_q  <= 1'b1;
         key_valid_q   <= 1'b0;
         key_code_q    <= 8'h00;
         key_ext_q     <= 1'b0;
         key_release_q <= 1'b0;
         key_repeat_q  <= 1'b0;
         ascii_q       <= 8'h00;
         key_count_q   <= 8'h00;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         ext_p_q       <= ext_p_d;
         brk_p_q       <= brk_p_d;
         shl_q         <= shl_d;
         shr_q         <= shr_d;
         last_vld_q    <= last_vld_d;
         last_key_q    <= last_key_d;
         nextdata_n_q  <= nextdata_n_d;
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_release_q <= key_release_d;
         key_repeat_q  <= key_repeat_d;
         ascii_q       <= ascii_d;
         key_count_q   <= key_count_d;
      end
   end

   assign nextdata_n  = nextdata_n_q;
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign key_ext     = key_ext_q;
   assign key_release = key_release_q;
   assign key_repeat  = key_repeat_q;
   assign ascii       = ascii_q;
   assign key_count   = key_count_q;
   assign shift_held  = shl_q | shr_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: FIFO model feeding the DUT, a key-event model
// checked every cycle, and literal expectations on captured events.
module tb_ps2_scancode_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_ready = 1'b0;
   logic       nextdata_n;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;
   logic       key_repeat;
   logic [7:0] ascii;
   logic [7:0] key_count;
   logic       shift_held;

   ps2_scancode_decoder dut (
      .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
      .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
      .key_ext(key_ext), .key_release(key_release), .key_repeat(key_repeat),
      .ascii(ascii), .key_count(key_count), .shift_held(shift_held)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Receiver FIFO model
   logic [7:0] fifo[$];
   logic       gate = 1'b1;
   logic       ready_drv = 1'b0;

   // Key-event model
   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   logic       m_pext, m_pbrk, m_ls, m_rs, m_last_vld;
   logic [8:0] m_last;
   logic [7:0] m_code, m_ascii, m_count;
   logic       m_ext, m_rel, m_rep, m_shift;
   logic       exp_valid = 1'b0;

   function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic sh);
      for (int i = 0; i < 26; i++)
         if (letter_codes[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == c) return 8'h30 + 8'(i);
      if (c == 8'h29) return 8'h20;
      if (c == 8'h5A) return 8'h0D;
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_pext = 0; m_pbrk = 0; m_ls = 0; m_rs = 0; m_last_vld = 0; m_last = '0;
      m_code = 0; m_ascii = 0; m_count = 0; m_ext = 0; m_rel = 0; m_rep = 0; m_shift = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [8:0] key;
      if (b == 8'hE0) m_pext = 1;
      else if (b == 8'hF0) m_pbrk = 1;
      else begin
         key     = {m_pext, b};
         m_code  = b;
         m_ext   = m_pext;
         m_rel   = m_pbrk;
         m_ascii = m_pext ? 8'h00 : model_ascii(b, m_ls | m_rs);
         if (!m_pbrk) begin
            m_rep = m_last_vld && (m_last == key);
            if (!m_rep) m_count = m_count + 8'd1;
            m_last_vld = 1;
            m_last = key;
         end else begin
            m_rep = 0;
            if (m_last_vld && m_last == key) m_last_vld = 0;
         end
         if (!m_pext && b == 8'h12) m_ls = !m_pbrk;
         if (!m_pext && b == 8'h59) m_rs = !m_pbrk;
         m_shift = m_ls | m_rs;
         m_pext = 0;
         m_pbrk = 0;
         exp_valid = 1;
      end
   endtask

   typedef struct {
      logic [7:0] code;
      logic       ext, rel, rep;
      logic [7:0] asc, cnt;
      logic       sh;
   } ev_t;
   ev_t ev_log[$];

   int cyc = 0;
   int last_pop = -100;
   int pulses = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         model_reset();
         exp_valid = 0;
      end else begin
         check("key_valid", key_valid, exp_valid);
         check("key_code", key_code, m_code);
         check("key_ext", key_ext, m_ext);
         check("key_release", key_release, m_rel);
         check("key_repeat", key_repeat, m_rep);
         check("ascii", ascii, m_ascii);
         check("key_count", key_count, m_count);
         check("shift_held", shift_held, m_shift);
         if (key_valid)
            ev_log.push_back('{key_code, key_ext, key_release, key_repeat, ascii, key_count, shift_held});
         exp_valid = 0;
         if (nextdata_n == 1'b0) begin
            pulses++;
            check("pop_only_when_ready", ready_drv, 1'b1);
            check("pop_spacing_ge3", (cyc - last_pop) >= 3, 1'b1);
            last_pop = cyc;
            if (fifo.size() > 0) model_byte(fifo.pop_front());
         end
      end
      ready_drv = gate && (fifo.size() > 0);
      ps2_ready = ready_drv;
      ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
   end

   task automatic drain(input string name);
      int n = 0;
      int budget = 30 * fifo.size() + 60;
      while (fifo.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, fifo.size() == 0, 1'b1);
      repeat (6) @(negedge clk);
   endtask

   task automatic chk_ev(input int idx, input logic [7:0] code, input logic ext, input logic rel,
                         input logic rep, input logic [7:0] asc, input logic [7:0] cnt, input logic sh);
      if (idx >= ev_log.size()) begin
         check($sformatf("ev%0d_present", idx), 0, 1);
      end else begin
         check($sformatf("ev%0d_code", idx), ev_log[idx].code, code);
         check($sformatf("ev%0d_ext", idx), ev_log[idx].ext, ext);
         check($sformatf("ev%0d_rel", idx), ev_log[idx].rel, rel);
         check($sformatf("ev%0d_rep", idx), ev_log[idx].rep, rep);
         check($sformatf("ev%0d_ascii", idx), ev_log[idx].asc, asc);
         check($sformatf("ev%0d_count", idx), ev_log[idx].cnt, cnt);
         check($sformatf("ev%0d_shift", idx), ev_log[idx].sh, sh);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int p0;
      int caught;
      logic [7:0] gbytes [7] = '{8'h2B, 8'h34, 8'hF0, 8'h2B, 8'hE0, 8'h12, 8'h1C};
      int         gaps   [7] = '{0, 1, 2, 3, 4, 5, 2};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_nextdata_n", nextdata_n, 1'b1);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_count", key_count, 8'h00);
      check("rst_key_code", key_code, 8'h00);
      check("rst_shift", shift_held, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Make/break
      base = ev_log.size();
      p0 = pulses;
      fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
      drain("makebreak");
      check("makebreak_pulses", pulses - p0, 3);
      check("makebreak_events", ev_log.size() - base, 2);
      chk_ev(base,     8'h1C, 0, 0, 0, 8'h61, 8'd1, 0);
      chk_ev(base + 1, 8'h1C, 0, 1, 0, 8'h61, 8'd1, 0);

      // Shift
      base = ev_log.size();
      fifo.push_back(8'h12); fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
      fifo.push_back(8'hF0); fifo.push_back(8'h12); fifo.push_back(8'h1C);
      drain("shift");
      chk_ev(base,     8'h12, 0, 0, 0, 8'h00, 8'd2, 1);
      chk_ev(base + 1, 8'h1C, 0, 0, 0, 8'h41, 8'd3, 1);
      chk_ev(base + 2, 8'h1C, 0, 1, 0, 8'h41, 8'd3, 1);
      chk_ev(base + 3, 8'h12, 0, 1, 0, 8'h00, 8'd3, 0);
      chk_ev(base + 4, 8'h1C, 0, 0, 0, 8'h61, 8'd4, 0);

      // Extended / repeat
      base = ev_log.size();
      fifo.push_back(8'hE0); fifo.push_back(8'h75); fifo.push_back(8'hE0); fifo.push_back(8'h75);
      fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
      drain("extrep");
      chk_ev(base,     8'h75, 1, 0, 0, 8'h00, 8'd5, 0);
      chk_ev(base + 1, 8'h75, 1, 0, 1, 8'h00, 8'd5, 0);
      chk_ev(base + 2, 8'h75, 1, 1, 0, 8'h00, 8'd5, 0);

      // Starvation gaps on ps2_ready
      base = ev_log.size();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         gate = 1'b0;
         fifo.push_back(gbytes[i]);
         repeat (gaps[i]) @(negedge clk);
         gate = 1'b1;
         drain("gap");
      end
      chk_ev(base,     8'h2B, 0, 0, 0, 8'h66, 8'd6, 0);
      chk_ev(base + 3, 8'h12, 1, 0, 0, 8'h00, 8'd8, 0);
      chk_ev(base + 4, 8'h1C, 0, 0, 0, 8'h61, 8'd9, 0);

      // Async reset during POP with a pending F0
      fifo.push_back(8'hF0);
      drain("rstpre");
      fifo.push_back(8'h1C);
      caught = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (nextdata_n == 1'b0) begin
            caught = 1;
            break;
         end
      end
      check("rst_pop_seen", caught, 1);
      rst = 1'b1;
      #1;
      check("rstpop_nextdata_n", nextdata_n, 1'b1);
      check("rstpop_key_code", key_code, 8'h00);
      check("rstpop_key_count", key_count, 8'h00);
      check("rstpop_ascii", ascii, 8'h00);
      check("rstpop_key_valid", key_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = ev_log.size();
      drain("rstpost");
      chk_ev(base, 8'h1C, 0, 0, 0, 8'h61, 8'd1, 0);

      // Count wrap
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      base = ev_log.size();
      for (int i = 0; i < 255; i++) fifo.push_back((i % 2 == 0) ? 8'h16 : 8'h1E);
      drain("wrap255");
      check("wrap_count_255", key_count, 8'd255);
      fifo.push_back(8'h1E);
      drain("wrap256");
      check("wrap_count_0", key_count, 8'd0);
      chk_ev(base, 8'h16, 0, 0, 0, 8'h31, 8'd1, 0);
      chk_ev(base + 255, 8'h1E, 0, 0, 0, 8'h32, 8'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
